// File: rtl/vga_sprite_bouncer_if.sv
// Pixel-stream, control and sprite-ROM signals of vga_sprite_bouncer.
// master: sync generator / ROM side; slave: the renderer.
interface vga_sprite_bouncer_if #(
    parameter int unsigned SPRITE_LOG2 = 7
);
    logic [9:0]             hpos;
    logic [9:0]             vpos;
    logic                   display_on;
    logic                   hsync_in;
    logic                   vsync_in;
    logic                   motion_en;
    logic [2:0]             speed;
    logic [5:0]             bg_color;
    logic [SPRITE_LOG2-1:0] rom_x;
    logic [SPRITE_LOG2-1:0] rom_y;
    logic [2:0]             rom_pixel;
    logic [5:0]             rgb;
    logic                   hsync_out;
    logic                   vsync_out;
    logic [9:0]             sprite_x;
    logic [9:0]             sprite_y;
    logic                   bounce;
    logic                   corner;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in, motion_en, speed, bg_color, rom_pixel,
        input  rom_x, rom_y, rgb, hsync_out, vsync_out, sprite_x, sprite_y, bounce, corner
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in, motion_en, speed, bg_color, rom_pixel,
        output rom_x, rom_y, rgb, hsync_out, vsync_out, sprite_x, sprite_y, bounce, corner
    );
endinterface

// File: rtl/vga_sprite_bouncer.sv
// Bouncing scaled-bitmap sprite renderer with 2-clock pixel pipeline and aligned sync.
// Optional macro VGA_SPRITE_TRANSPARENT_EN makes palette index 0 show the background.
module vga_sprite_bouncer #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned SPRITE_LOG2 = 7,
    parameter int unsigned SCALE_LOG2  = 0,
    parameter int unsigned INIT_X      = 256,
    parameter int unsigned INIT_Y      = 128,
    parameter logic [47:0] PALETTE     = 48'hFFE_BA6_1C5_0C0
) (
    input logic                 clk,
    input logic                 reset,
    vga_sprite_bouncer_if.slave vga
);
    localparam int unsigned W       = 1 << (SPRITE_LOG2 + SCALE_LOG2);
    localparam logic [10:0] W11     = 11'(W);
    localparam logic [10:0] LIMIT_X = 11'(H_RES - W);
    localparam logic [10:0] LIMIT_Y = 11'(V_RES - W);

    typedef enum logic {DirPos = 1'b0, DirNeg = 1'b1} dir_e;

    typedef struct packed {
        logic [9:0] pos;
        dir_e       dir;
        logic       refl;
    } axis_t;

    // One axis of the per-frame move, clamped and reflected at 0 and limit.
    function automatic axis_t axis_next(input logic [9:0] p, input dir_e d,
                                        input logic [10:0] limit, input logic [2:0] spd);
        axis_t      r;
        logic [10:0] sum;
        sum    = {1'b0, p} + {8'd0, spd};
        r.pos  = p;
        r.dir  = d;
        r.refl = 1'b0;
        if (d == DirPos) begin
            if (sum >= limit) begin
                r.pos  = limit[9:0];
                r.dir  = DirNeg;
                r.refl = 1'b1;
            end else begin
                r.pos = sum[9:0];
            end
        end else begin
            if ({1'b0, p} <= {8'd0, spd}) begin
                r.pos  = 10'd0;
                r.dir  = DirPos;
                r.refl = 1'b1;
            end else begin
                r.pos = p - {7'd0, spd};
            end
        end
        return r;
    endfunction

    logic [9:0]             sprite_x_q, sprite_y_q;
    dir_e                   dir_x_q, dir_y_q;
    logic                   bounce_q, corner_q;
    logic [SPRITE_LOG2-1:0] rom_x_q, rom_y_q;
    logic                   hit_q, de_q;
    logic [5:0]             rgb_q, rgb_d;
    logic [1:0]             hs_pipe_q, vs_pipe_q;

    logic [10:0] dx, dy;
    logic        hit;
    logic        update;
    axis_t       nx, ny;
    logic [5:0]  palette [8];
    logic [5:0]  pal_color;

    // Stage 1: sprite-relative coordinates; negative offsets wrap high and miss.
    always_comb begin
        dx  = {1'b0, vga.hpos} - {1'b0, sprite_x_q};
        dy  = {1'b0, vga.vpos} - {1'b0, sprite_y_q};
        hit = vga.display_on && (dx < W11) && (dy < W11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_x_q <= '0;
            rom_y_q <= '0;
            hit_q   <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            rom_x_q <= dx[SCALE_LOG2 +: SPRITE_LOG2];
            rom_y_q <= dy[SCALE_LOG2 +: SPRITE_LOG2];
            hit_q   <= hit;
            de_q    <= vga.display_on;
        end
    end

    // Stage 2: palette lookup on the ROM's combinational answer.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            palette[i] = PALETTE[6*i +: 6];
        end
        pal_color = palette[vga.rom_pixel];
        rgb_d     = 6'd0;
        if (!de_q) begin
            rgb_d = 6'd0;
        end else if (hit_q) begin
`ifdef VGA_SPRITE_TRANSPARENT_EN
            rgb_d = (vga.rom_pixel == 3'd0) ? vga.bg_color : pal_color;
`else
            rgb_d = pal_color;
`endif
        end else begin
            rgb_d = vga.bg_color;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q     <= 6'd0;
            hs_pipe_q <= 2'b11;
            vs_pipe_q <= 2'b11;
        end else begin
            rgb_q     <= rgb_d;
            hs_pipe_q <= {hs_pipe_q[0], vga.hsync_in};
            vs_pipe_q <= {vs_pipe_q[0], vga.vsync_in};
        end
    end

    // Single update point in vertical blanking keeps the position stable while drawing.
    always_comb begin
        update = (vga.hpos == 10'd0) && (vga.vpos == 10'(V_RES)) && vga.motion_en
                 && (vga.speed != 3'd0);
        nx = axis_next(sprite_x_q, dir_x_q, LIMIT_X, vga.speed);
        ny = axis_next(sprite_y_q, dir_y_q, LIMIT_Y, vga.speed);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sprite_x_q <= 10'(INIT_X);
            sprite_y_q <= 10'(INIT_Y);
            dir_x_q    <= DirPos;
            dir_y_q    <= DirPos;
            bounce_q   <= 1'b0;
            corner_q   <= 1'b0;
        end else if (update) begin
            sprite_x_q <= nx.pos;
            sprite_y_q <= ny.pos;
            dir_x_q    <= nx.dir;
            dir_y_q    <= ny.dir;
            bounce_q   <= nx.refl | ny.refl;
            corner_q   <= nx.refl & ny.refl;
        end else begin
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end
    end

    assign vga.rom_x     = rom_x_q;
    assign vga.rom_y     = rom_y_q;
    assign vga.rgb       = rgb_q;
    assign vga.hsync_out = hs_pipe_q[1];
    assign vga.vsync_out = vs_pipe_q[1];
    assign vga.sprite_x  = sprite_x_q;
    assign vga.sprite_y  = sprite_y_q;
    assign vga.bounce    = bounce_q;
    assign vga.corner    = corner_q;
endmodule

// File: tb/tb_vga_sprite_bouncer.sv
// Directed bench for vga_sprite_bouncer: a default-size instance and a 2x-scaled
// instance placed so both axes hit their limits together.
module tb_vga_sprite_bouncer;
    localparam logic [5:0]  PAL0 = 6'h07;
    localparam logic [5:0]  PAL3 = 6'h30;
    localparam logic [47:0] PAL  = {6'h3F, 6'h2A, 6'h15, 6'h0C, PAL3, 6'h02, 6'h01, PAL0};
    localparam logic [5:0]  BG   = 6'h05;
`ifdef VGA_SPRITE_TRANSPARENT_EN
    localparam logic [5:0]  TRANSP_EXP = BG;
`else
    localparam logic [5:0]  TRANSP_EXP = PAL0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] rom_val;
    int         checks;
    int         failures;

    vga_sprite_bouncer_if #(.SPRITE_LOG2(7)) ifa ();
    vga_sprite_bouncer_if #(.SPRITE_LOG2(7)) ifb ();

    assign ifa.rom_pixel = rom_val;
    assign ifb.rom_pixel = rom_val;

    vga_sprite_bouncer #(
        .H_RES(640), .V_RES(480), .SPRITE_LOG2(7), .SCALE_LOG2(0),
        .INIT_X(256), .INIT_Y(128), .PALETTE(PAL)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .vga  (ifa)
    );

    vga_sprite_bouncer #(
        .H_RES(640), .V_RES(480), .SPRITE_LOG2(7), .SCALE_LOG2(1),
        .INIT_X(380), .INIT_Y(220), .PALETTE(PAL)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .vga  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic de);
        ifa.hpos = h; ifa.vpos = v; ifa.display_on = de;
        ifb.hpos = h; ifb.vpos = v; ifb.display_on = de;
    endtask

    task automatic set_sync(input logic hs, input logic vs);
        ifa.hsync_in = hs; ifa.vsync_in = vs;
        ifb.hsync_in = hs; ifb.vsync_in = vs;
    endtask

    task automatic set_speed(input logic [2:0] s);
        ifa.speed = s;
        ifb.speed = s;
    endtask

    // Present a pixel and wait for it to reach rgb.
    task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic de);
        drive(h, v, de);
        @(negedge clk);
        @(negedge clk);
    endtask

    // One update cycle; returns in the cycle after it, where the new position and pulses show.
    task automatic tick();
        drive(10'd0, 10'd480, 1'b0);
        @(negedge clk);
        drive(10'd1, 10'd481, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rom_val  = 3'd3;
        drive(10'd100, 10'd100, 1'b0);
        set_sync(1'b1, 1'b1);
        ifa.motion_en = 1'b0;
        ifb.motion_en = 1'b0;
        set_speed(3'd0);
        ifa.bg_color = BG;
        ifb.bg_color = BG;

        #12;
        check("rst_rgb", 16'(ifa.rgb), 16'h0);
        check("rst_hsync", 16'(ifa.hsync_out), 16'h1);
        check("rst_vsync", 16'(ifa.vsync_out), 16'h1);
        check("rst_sprite_x", 16'(ifa.sprite_x), 16'd256);
        check("rst_sprite_y", 16'(ifa.sprite_y), 16'd128);
        check("rst_rom_x", 16'(ifa.rom_x), 16'h0);
        check("rst_rom_y", 16'(ifa.rom_y), 16'h0);
        check("rst_bounce", 16'(ifa.bounce), 16'h0);
        check("rst_corner", 16'(ifa.corner), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Static rendering and sprite boundaries.
        pixel(10'd256, 10'd128, 1'b1);
        check("in_sprite", 16'(ifa.rgb), 16'(PAL3));
        pixel(10'd255, 10'd128, 1'b1);
        check("left_of_sprite", 16'(ifa.rgb), 16'(BG));
        pixel(10'd256, 10'd127, 1'b1);
        check("above_sprite", 16'(ifa.rgb), 16'(BG));
        pixel(10'd383, 10'd255, 1'b1);
        check("bottom_right", 16'(ifa.rgb), 16'(PAL3));
        pixel(10'd384, 10'd128, 1'b1);
        check("past_right", 16'(ifa.rgb), 16'(BG));
        pixel(10'd256, 10'd128, 1'b0);
        check("blanking", 16'(ifa.rgb), 16'h0);
        pixel(10'd300, 10'd140, 1'b1);
        check("rom_x", 16'(ifa.rom_x), 16'd44);
        check("rom_y", 16'(ifa.rom_y), 16'd12);
        rom_val = 3'd0;
        pixel(10'd256, 10'd128, 1'b1);
        check("index0", 16'(ifa.rgb), 16'(TRANSP_EXP));
        rom_val = 3'd3;

        // Sync delay.
        set_sync(1'b0, 1'b0);
        @(negedge clk);
        check("hsync_d1", 16'(ifa.hsync_out), 16'h1);
        @(negedge clk);
        check("hsync_d2", 16'(ifa.hsync_out), 16'h0);
        check("vsync_d2", 16'(ifa.vsync_out), 16'h0);
        set_sync(1'b1, 1'b1);

        // Scaled instance: 2x2 screen pixels per ROM pixel.
        pixel(10'd382, 10'd225, 1'b1);
        check("scale_rom_x", 16'(ifb.rom_x), 16'd1);
        check("scale_rom_y", 16'(ifb.rom_y), 16'd2);

        // Motion gating.
        set_speed(3'd4);
        tick();
        check("no_motion_en", 16'(ifa.sprite_x), 16'd256);
        ifa.motion_en = 1'b1;
        set_speed(3'd0);
        tick();
        check("speed_zero", 16'(ifa.sprite_x), 16'd256);
        check("speed_zero_bounce", 16'(ifa.bounce), 16'h0);
        set_speed(3'd4);
        drive(10'd1, 10'd480, 1'b0);
        @(negedge clk);
        drive(10'd0, 10'd479, 1'b0);
        @(negedge clk);
        check("not_update_pos", 16'(ifa.sprite_x), 16'd256);

        tick();
        check("move1_x", 16'(ifa.sprite_x), 16'd260);
        check("move1_y", 16'(ifa.sprite_y), 16'd132);
        tick();
        check("move2_x", 16'(ifa.sprite_x), 16'd264);
        tick();
        check("move3_x", 16'(ifa.sprite_x), 16'd268);
        check("move3_y", 16'(ifa.sprite_y), 16'd140);
        check("move3_bounce", 16'(ifa.bounce), 16'h0);

        // Run toward the right edge; y reflects at 352 on the 31st step.
        set_speed(3'd7);
        for (int i = 0; i < 34; i++) begin
            tick();
            if (i == 30) begin
                check("y_edge_y", 16'(ifa.sprite_y), 16'd352);
                check("y_edge_bounce", 16'(ifa.bounce), 16'h1);
                check("y_edge_corner", 16'(ifa.corner), 16'h0);
            end
        end
        check("run_x", 16'(ifa.sprite_x), 16'd506);
        check("run_y", 16'(ifa.sprite_y), 16'd331);
        set_speed(3'd4);
        tick();
        check("pre_edge_x", 16'(ifa.sprite_x), 16'd510);
        check("pre_edge_bounce", 16'(ifa.bounce), 16'h0);
        tick();
        check("right_edge_x", 16'(ifa.sprite_x), 16'd512);
        check("right_edge_y", 16'(ifa.sprite_y), 16'd323);
        check("right_edge_bounce", 16'(ifa.bounce), 16'h1);
        check("right_edge_corner", 16'(ifa.corner), 16'h0);
        @(negedge clk);
        check("bounce_one_cycle", 16'(ifa.bounce), 16'h0);
        tick();
        check("after_flip_x", 16'(ifa.sprite_x), 16'd508);
        check("after_flip_y", 16'(ifa.sprite_y), 16'd319);
        ifa.motion_en = 1'b0;

        // Corner on the scaled instance (limits 384/224).
        ifb.motion_en = 1'b1;
        tick();
        check("corner_x", 16'(ifb.sprite_x), 16'd384);
        check("corner_y", 16'(ifb.sprite_y), 16'd224);
        check("corner_bounce", 16'(ifb.bounce), 16'h1);
        check("corner_pulse", 16'(ifb.corner), 16'h1);
        @(negedge clk);
        check("corner_one_cycle", 16'(ifb.corner), 16'h0);

        // Back toward the origin; y lands exactly on speed before reflecting at 0.
        set_speed(3'd7);
        for (int i = 0; i < 31; i++) tick();
        tick();
        check("top_edge_y", 16'(ifb.sprite_y), 16'd0);
        check("top_edge_x", 16'(ifb.sprite_x), 16'd160);
        check("top_edge_bounce", 16'(ifb.bounce), 16'h1);
        check("top_edge_corner", 16'(ifb.corner), 16'h0);
        for (int i = 0; i < 22; i++) tick();
        tick();
        check("left_edge_x", 16'(ifb.sprite_x), 16'd0);
        check("left_edge_y", 16'(ifb.sprite_y), 16'd161);
        check("left_edge_bounce", 16'(ifb.bounce), 16'h1);
        ifb.motion_en = 1'b0;

        // Asynchronous reset mid-line.
        set_sync(1'b0, 1'b1);
        pixel(10'd508, 10'd319, 1'b1);
        check("pre_reset_rgb", 16'(ifa.rgb), 16'(PAL3));
        check("pre_reset_hsync", 16'(ifa.hsync_out), 16'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rgb", 16'(ifa.rgb), 16'h0);
        check("async_hsync", 16'(ifa.hsync_out), 16'h1);
        check("async_sprite_x", 16'(ifa.sprite_x), 16'd256);
        check("async_sprite_y", 16'(ifa.sprite_y), 16'd128);
        @(negedge clk);
        reset = 1'b0;
        set_sync(1'b1, 1'b1);
        pixel(10'd256, 10'd128, 1'b1);
        check("post_reset_render", 16'(ifa.rgb), 16'(PAL3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
